dr_sync_rx: RTL and testbench
=============================

Name: dr_sync_rx

Overview:
- Dual-rail to synchronous bridge. It consumes the dual-rail output link of the asynchronous Fibonacci/arithmetic datapath and converts each completed dual-rail token to a binary word.
- Words are buffered in a small FIFO and presented on a clocked valid/ready stream.
- The block generates the link acknowledge, so the asynchronous producer is throttled by downstream backpressure.
- Sits directly downstream of the producer's `out`/`ack_i` link and is the boundary into clocked logic.

Parameters:
- WIDTH, 32, data bits per token (dual-rail link carries WIDTH x RAIL_NUM wires).
- ENC, "TP", link protocol. "TP" is two-phase transition dual-rail; "FP" is four-phase return-to-zero dual-rail.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-low reset.
- in  input  [WIDTH-1:0][RAIL_NUM-1:0]  dual-rail data from producer. Rail 1 = logic 1, rail 0 = logic 0.
- ack_o  output  1  link acknowledge to producer's ack_i.
- m_data  output  WIDTH  decoded word at FIFO head.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  consumer accepts head when high with m_valid.
- tok_cnt  output  32  tokens accepted since reset; wraps modulo 2^32.
- err  output  1  sticky protocol error (FP only).

Behaviour:
- Reset (rst=0, asynchronous):
  - ack_o=0, FIFO empty, m_valid=0, m_data=0.
  - tok_cnt=0, err=0.
  - prev-rail register = all 0, state = WAIT_TOK.
  - The producer link is required to be reset concurrently, so all rails read 0.
- Every rail passes through a 2-flop synchronizer (dr_sync2). All logic below uses the synchronized rails s[i][r].
- TP completion and decode:
  - done = AND over bits of (s[i][1]^p[i][1]) ^ (s[i][0]^p[i][0]).
  - Decoded bit i = s[i][1]^p[i][1].
- FP completion and decode:
  - done = AND over bits of (s[i][1] | s[i][0]).
  - spacer = all rails 0.
  - Decoded bit i = s[i][1].
- FSM:
  - WAIT_TOK: on a clock edge where done=1 and FIFO not full:
    - push decoded word; tok_cnt+1.
    - TP: p <= s, ack_o toggles, stay in WAIT_TOK.
    - FP: ack_o <= 1, go to WAIT_SPC.
  - If done=1 but FIFO full: hold, no ack change, token stays pending.
  - WAIT_SPC (FP only): when spacer=1, ack_o <= 0 and go to WAIT_TOK.
- Full is evaluated on the registered FIFO count. A pop in the same cycle does not free space for a push in that cycle.
- Latency:
  - From the last rail settling to the push edge: 2-3 clk (synchronizer plus detect).
  - Push to m_valid=1: 1 clk.
  - ack_o changes on the push edge.
- FIFO:
  - Pop occurs when m_valid & m_ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - m_data holds the head value and is stable while m_valid=1 and m_ready=0.
- Partial tokens (some bits complete) never push. Single-rail monotonic transitions make sampling skew harmless.
- err (FP):
  - Set when any bit shows s[i][1]&s[i][0].
  - Set when any rail rises while in WAIT_SPC before spacer is seen.
  - Cleared only by reset. Data flow continues regardless of err.
- TP never sets err.
- Reset mid-token: all state clears immediately, and any partially received token is discarded.

Decomposition:
- Package dr_pkg holds:
  - RAIL_NUM=2, RAIL_0=0, RAIL_1=1.
  - enc_e enum {ENC_TP, ENC_FP}, with a string-to-enum mapping function.
  - rx_state_e {WAIT_TOK, WAIT_SPC}.
- Sub-module dr_sync2: parameterised-width 2-flop synchronizer with async active-low reset to 0.
- FIFO stays inline: a small register array with pointers.

Test Plan:
- TP single token: drive transitions encoding 0x0000_0005, m_ready=1.
  - ack_o toggles 0->1 within 4 clk.
  - m_data=5 with m_valid for 1 clk; tok_cnt=1.
- TP Fibonacci stream: behavioural producer sends 0,1,1,2,3,5,8,13, each after seeing its ack toggle.
  - Consumer reads exactly that sequence; tok_cnt=8; err=0.
- Backpressure: DEPTH=4, m_ready=0, producer offers 6 tokens.
  - Exactly 4 acks are issued and the 5th is held.
  - Raising m_ready drains 4 words, then remaining tokens are acked in order.
- FP handshake: send 0xDEADBEEF, then spacer.
  - ack_o rises after the token and falls only after all rails are 0.
  - m_data=0xDEADBEEF.
- FP error: assert both rails of bit 3.
  - err=1 within 3 clk and remains set through later valid tokens, until reset.
- Reset mid-token: drive half the bits of a TP token, then assert rst=0 for 2 clk.
  - All outputs return to reset values; no push occurs.
  - After release, a fresh token 0x7 is received correctly.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared types and per-bit dual-rail helpers for the dual-rail receive bridge.
// Rail 1 carries logic 1 and rail 0 carries logic 0 for every data bit.
package dr_pkg;

   localparam int RAIL_NUM = 2;
   localparam int RAIL_0   = 0;
   localparam int RAIL_1   = 1;

   typedef enum logic {
      ENC_TP = 1'b0,
      ENC_FP = 1'b1
   } enc_e;

   typedef enum logic {
      WAIT_TOK = 1'b0,
      WAIT_SPC = 1'b1
   } rx_state_e;

   function automatic enc_e enc_from_str(input string s);
      enc_e r_enc;
      if (s == "FP") begin
         r_enc = ENC_FP;
      end else begin
         r_enc = ENC_TP;
      end
      return r_enc;
   endfunction

   // A two-phase bit is complete when exactly one of its rails has toggled.
   function automatic logic tp_bit_done(input logic [RAIL_NUM-1:0] s,
                                        input logic [RAIL_NUM-1:0] p);
      return (s[RAIL_1] ^ p[RAIL_1]) ^ (s[RAIL_0] ^ p[RAIL_0]);
   endfunction

   function automatic logic tp_bit_val(input logic [RAIL_NUM-1:0] s,
                                       input logic [RAIL_NUM-1:0] p);
      return s[RAIL_1] ^ p[RAIL_1];
   endfunction

   function automatic logic fp_bit_done(input logic [RAIL_NUM-1:0] s);
      return s[RAIL_1] | s[RAIL_0];
   endfunction

   function automatic logic fp_bit_bad(input logic [RAIL_NUM-1:0] s);
      return s[RAIL_1] & s[RAIL_0];
   endfunction

endpackage

// File: rtl/dr_sync2.sv
// Two-flop synchronizer bank, one flop pair per input bit, async active-low
// reset to 0.
module dr_sync2 #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Metastability settling stage followed by the stable output stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/dr_sync_rx.sv
// Dual-rail link receiver: synchronizes the rails, detects completed tokens,
// acknowledges the producer and queues decoded words on a valid/ready stream.
module dr_sync_rx
   import dr_pkg::*;
#(
   parameter int    WIDTH = 32,
   parameter string ENC   = "TP",
   parameter int    DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WIDTH-1:0][RAIL_NUM-1:0] in,
   output logic                           ack_o,
   output logic [WIDTH-1:0]               m_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [31:0]                    tok_cnt,
   output logic                           err
);

   localparam enc_e            ENC_SEL  = enc_from_str(ENC);
   localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

   logic [WIDTH*RAIL_NUM-1:0]      w_sync_q;
   logic [WIDTH-1:0][RAIL_NUM-1:0] w_s;

   logic [WIDTH-1:0][RAIL_NUM-1:0] r_prev;
   logic [WIDTH*RAIL_NUM-1:0]      r_s_q;
   rx_state_e                      r_state;
   logic                           r_ack;
   logic [WIDTH-1:0]               r_mem [DEPTH];
   logic [AW-1:0]                  r_wr_ptr;
   logic [AW-1:0]                  r_rd_ptr;
   logic [AW:0]                    r_count;
   logic                           r_valid;
   logic [31:0]                    r_tok_cnt;
   logic                           r_err;

   logic             w_done_tp;
   logic             w_done_fp;
   logic             w_both;
   logic [WIDTH-1:0] w_word_tp;
   logic [WIDTH-1:0] w_word_fp;
   logic             w_done;
   logic [WIDTH-1:0] w_word;
   logic             w_spacer;
   logic             w_rise;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_prev_ld;
   logic             w_err_set;
   logic [AW:0]      w_count_nxt;
   rx_state_e        w_state_nxt;
   logic             w_ack_nxt;

   dr_sync2 #(
      .W (WIDTH*RAIL_NUM)
   ) u_sync (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_d     (in),
      .o_q     (w_sync_q)
   );

   assign w_s      = w_sync_q;
   assign w_spacer = ~(|w_sync_q);
   assign w_rise   = |(w_sync_q & ~r_s_q);
   assign w_full   = (r_count == CNT_FULL);
   assign w_pop    = r_valid & m_ready;

   // Per-bit completion and decode for both link encodings.
   always_comb begin
      w_done_tp = 1'b1;
      w_done_fp = 1'b1;
      w_both    = 1'b0;
      w_word_tp = '0;
      w_word_fp = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_word_tp[i] = tp_bit_val(w_s[i], r_prev[i]);
         w_word_fp[i] = w_s[i][RAIL_1];
         w_done_tp    = w_done_tp & tp_bit_done(w_s[i], r_prev[i]);
         w_done_fp    = w_done_fp & fp_bit_done(w_s[i]);
         w_both       = w_both | fp_bit_bad(w_s[i]);
      end
   end

   // Encoding select and protocol error detection.
   always_comb begin
      if (ENC_SEL == ENC_FP) begin
         w_done    = w_done_fp;
         w_word    = w_word_fp;
         w_err_set = w_both | ((r_state == WAIT_SPC) & w_rise);
      end else begin
         w_done    = w_done_tp;
         w_word    = w_word_tp;
         w_err_set = 1'b0;
      end
   end

   // Handshake FSM: next state, acknowledge level and push strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = r_ack;
      w_push      = 1'b0;
      w_prev_ld   = 1'b0;
      case (r_state)
         WAIT_TOK: begin
            if (w_done && !w_full) begin
               w_push = 1'b1;
               if (ENC_SEL == ENC_FP) begin
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = WAIT_SPC;
               end else begin
                  w_ack_nxt   = ~r_ack;
                  w_prev_ld   = 1'b1;
                  w_state_nxt = WAIT_TOK;
               end
            end else begin
               w_state_nxt = WAIT_TOK;
            end
         end
         WAIT_SPC: begin
            if (w_spacer) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = WAIT_TOK;
            end else begin
               w_state_nxt = WAIT_SPC;
            end
         end
         default: begin
            w_ack_nxt   = 1'b0;
            w_state_nxt = WAIT_TOK;
         end
      endcase
   end

   // FIFO occupancy update; a same-cycle pop never makes room for the push.
   always_comb begin
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Handshake state, rail history and sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= WAIT_TOK;
         r_ack   <= 1'b0;
         r_prev  <= '0;
         r_s_q   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_s_q   <= w_sync_q;
         if (w_prev_ld) begin
            r_prev <= w_s;
         end else begin
            r_prev <= r_prev;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
      end
   end

   // Word FIFO storage, pointers, occupancy and token counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_tok_cnt <= 32'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            r_tok_cnt       <= r_tok_cnt + 32'd1;
         end else begin
            r_wr_ptr  <= r_wr_ptr;
            r_tok_cnt <= r_tok_cnt;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
      end
   end

   assign ack_o   = r_ack;
   assign m_data  = r_mem[r_rd_ptr];
   assign m_valid = r_valid;
   assign tok_cnt = r_tok_cnt;
   assign err     = r_err;

endmodule

// File: tb/tb_dr_sync_rx.sv
// Scoreboard bench for dr_sync_rx: a TP instance and an FP instance driven by
// behavioural dual-rail producers; monitors pop expected words on each accept.
module tb_dr_sync_rx;
   import dr_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                       rst;
   logic [W-1:0][RAIL_NUM-1:0] tp_in, fp_in;
   logic                       tp_ack, fp_ack;
   logic [W-1:0]               tp_data, fp_data;
   logic                       tp_valid, fp_valid;
   logic                       tp_ready, fp_ready;
   logic [31:0]                tp_cnt, fp_cnt;
   logic                       tp_err, fp_err;

   int n_chk = 0;
   int n_err = 0;
   int tp_vcyc = 0;
   logic [W-1:0] tp_q[$];
   logic [W-1:0] fp_q[$];
   logic [31:0]  fib [8] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};

   dr_sync_rx #(.WIDTH(W), .ENC("TP"), .DEPTH(4)) u_tp (
      .clk(clk), .rst(rst), .in(tp_in), .ack_o(tp_ack), .m_data(tp_data),
      .m_valid(tp_valid), .m_ready(tp_ready), .tok_cnt(tp_cnt), .err(tp_err));

   dr_sync_rx #(.WIDTH(W), .ENC("FP"), .DEPTH(4)) u_fp (
      .clk(clk), .rst(rst), .in(fp_in), .ack_o(fp_ack), .m_data(fp_data),
      .m_valid(fp_valid), .m_ready(fp_ready), .tok_cnt(fp_cnt), .err(fp_err));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // TP output monitor
   always @(negedge clk) begin
      if (rst && tp_valid) tp_vcyc++;
      if (rst && tp_valid && tp_ready) begin
         if (tp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL tp_extra_word: got 0x%08h expected no word", tp_data);
         end else begin
            check("tp_word", tp_data, tp_q.pop_front());
         end
      end
   end

   // FP output monitor
   always @(negedge clk) begin
      if (rst && fp_valid && fp_ready) begin
         if (fp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL fp_extra_word: got 0x%08h expected no word", fp_data);
         end else begin
            check("fp_word", fp_data, fp_q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tp_drive(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         if (w[i]) tp_in[i][RAIL_1] = ~tp_in[i][RAIL_1];
         else      tp_in[i][RAIL_0] = ~tp_in[i][RAIL_0];
      end
   endtask

   task automatic fp_drive(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         fp_in[i][RAIL_1] = w[i];
         fp_in[i][RAIL_0] = ~w[i];
      end
   endtask

   task automatic wait_ack(input bit fp, input logic lvl, input int max,
                           output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      while (!ok && cyc < max) begin
         tick(1);
         cyc++;
         ok = fp ? (fp_ack === lvl) : (tp_ack === lvl);
      end
   endtask

   task automatic tp_send(input logic [W-1:0] w, input int max, output bit ok, output int cyc);
      logic a0;
      a0 = tp_ack;
      tp_q.push_back(w);
      tp_drive(w);
      wait_ack(1'b0, ~a0, max, ok, cyc);
   endtask

   task automatic fp_send(input logic [W-1:0] w, input string nm);
      bit ok;
      int cyc;
      fp_q.push_back(w);
      fp_drive(w);
      wait_ack(1'b1, 1'b1, 6, ok, cyc);
      check({nm, "_ack_rise"}, 32'(ok), 32'd1);
      fp_in = '0;
      wait_ack(1'b1, 1'b0, 6, ok, cyc);
      check({nm, "_ack_fall"}, 32'(ok), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit       ok;
      int       cyc;
      int       n_ack;
      int       v0;
      logic     a0;

      rst = 1'b0; tp_in = '0; fp_in = '0; tp_ready = 1'b0; fp_ready = 1'b1;
      tick(3);
      check("rst_tp_ack", 32'(tp_ack), 32'd0);
      check("rst_tp_valid", 32'(tp_valid), 32'd0);
      check("rst_tp_data", tp_data, 32'd0);
      check("rst_tp_cnt", tp_cnt, 32'd0);
      check("rst_tp_err", 32'(tp_err), 32'd0);
      check("rst_fp_ack", 32'(fp_ack), 32'd0);
      check("rst_fp_err", 32'(fp_err), 32'd0);
      rst = 1'b1;
      tick(2);

      // Single TP token
      tp_ready = 1'b1;
      v0 = tp_vcyc;
      tp_send(32'h0000_0005, 6, ok, cyc);
      check("tp1_ack", 32'(ok), 32'd1);
      check("tp1_ack_within_4", 32'(cyc <= 4), 32'd1);
      tick(4);
      check("tp1_cnt", tp_cnt, 32'd1);
      check("tp1_valid_cycles", 32'(tp_vcyc - v0), 32'd1);
      check("tp1_drained", 32'(tp_q.size()), 32'd0);

      // Fibonacci stream
      for (int k = 0; k < 8; k++) begin
         tp_send(fib[k], 6, ok, cyc);
         check("fib_ack", 32'(ok), 32'd1);
      end
      tick(4);
      check("fib_cnt", tp_cnt, 32'd9);
      check("fib_err", 32'(tp_err), 32'd0);
      check("fib_drained", 32'(tp_q.size()), 32'd0);

      // Backpressure: four fit, the fifth stays pending
      tp_ready = 1'b0;
      tick(2);
      n_ack = 0;
      for (int k = 0; k < 4; k++) begin
         tp_send(32'hA0 + 32'(k), 6, ok, cyc);
         if (ok) n_ack++;
      end
      a0 = tp_ack;
      tp_q.push_back(32'hA4);
      tp_drive(32'hA4);
      wait_ack(1'b0, ~a0, 10, ok, cyc);
      check("bp_5th_held", 32'(ok), 32'd0);
      check("bp_acks", 32'(n_ack), 32'd4);
      check("bp_head_stable", tp_data, 32'hA0);
      check("bp_valid", 32'(tp_valid), 32'd1);
      check("bp_cnt", tp_cnt, 32'd13);
      tp_ready = 1'b1;
      wait_ack(1'b0, ~a0, 12, ok, cyc);
      check("bp_5th_acked", 32'(ok), 32'd1);
      tp_send(32'hA5, 6, ok, cyc);
      check("bp_6th_acked", 32'(ok), 32'd1);
      tick(8);
      check("bp_drained", 32'(tp_q.size()), 32'd0);
      check("bp_cnt_final", tp_cnt, 32'd15);

      // FP handshake with staged spacer
      fp_q.push_back(32'hDEAD_BEEF);
      fp_drive(32'hDEAD_BEEF);
      wait_ack(1'b1, 1'b1, 6, ok, cyc);
      check("fp_ack_rise", 32'(ok), 32'd1);
      tick(5);
      check("fp_ack_hold_token", 32'(fp_ack), 32'd1);
      for (int i = 0; i < 16; i++) fp_in[i] = '0;
      tick(5);
      check("fp_ack_hold_partial_spacer", 32'(fp_ack), 32'd1);
      fp_in = '0;
      wait_ack(1'b1, 1'b0, 6, ok, cyc);
      check("fp_ack_fall", 32'(ok), 32'd1);
      check("fp_err_clean", 32'(fp_err), 32'd0);

      // FP error: both rails of bit 3
      for (int i = 0; i < W; i++) fp_in[i][RAIL_0] = 1'b1;
      fp_in[3][RAIL_1] = 1'b1;
      fp_q.push_back(32'h0000_0008);
      tick(3);
      check("fp_err_set", 32'(fp_err), 32'd1);
      wait_ack(1'b1, 1'b1, 6, ok, cyc);
      check("fp_err_tok_ack", 32'(ok), 32'd1);
      fp_in = '0;
      wait_ack(1'b1, 1'b0, 6, ok, cyc);
      check("fp_err_tok_release", 32'(ok), 32'd1);
      fp_send(32'h1234_5678, "fp_after_err");
      tick(3);
      check("fp_err_sticky", 32'(fp_err), 32'd1);
      check("fp_cnt", fp_cnt, 32'd3);
      check("fp_drained", 32'(fp_q.size()), 32'd0);

      // Reset with a half-received TP token
      tp_ready = 1'b0;
      for (int i = 0; i < 16; i++) tp_in[i][RAIL_1] = ~tp_in[i][RAIL_1];
      tick(4);
      check("mid_no_push", tp_cnt, 32'd15);
      rst = 1'b0; tp_in = '0; fp_in = '0;
      tick(2);
      check("mid_rst_ack", 32'(tp_ack), 32'd0);
      check("mid_rst_valid", 32'(tp_valid), 32'd0);
      check("mid_rst_data", tp_data, 32'd0);
      check("mid_rst_cnt", tp_cnt, 32'd0);
      check("mid_rst_fp_err", 32'(fp_err), 32'd0);
      check("mid_rst_fp_cnt", fp_cnt, 32'd0);
      rst = 1'b1;
      tick(3);
      check("post_rst_no_push", tp_cnt, 32'd0);
      tp_ready = 1'b1;
      tp_send(32'h0000_0007, 6, ok, cyc);
      check("post_rst_ack", 32'(ok), 32'd1);
      tick(4);
      check("post_rst_cnt", tp_cnt, 32'd1);
      check("post_rst_drained", 32'(tp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
